// File: rtl/itcm_ahb_slave_pkg.sv
// Shared AHB-Lite encodings, FSM states and helpers for the ITCM responder.
package itcm_ahb_slave_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam int unsigned WAIT_CNT_W = 4;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned LANES      = DATA_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   // Address-phase attributes carried into the data phase (word index kept separately).
   typedef struct packed {
      logic       write;
      logic [2:0] size;
      logic [1:0] lane;
   } aphase_t;

   function automatic logic is_active(input logic [1:0] trans);
      case (trans)
         HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
         default:                   return 1'b0;
      endcase
   endfunction

   // Oversized transfers are rejected separately, so only half/word need alignment.
   function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         HSIZE_HALF: return ~lo[0];
         HSIZE_WORD: return (lo == 2'b00);
         default:    return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/itcm_byte_mask.sv
// Little-endian write-lane decode from transfer size and the low address bits.
module itcm_byte_mask
   import itcm_ahb_slave_pkg::*;
(
   input  logic [2:0]       size,
   input  logic [1:0]       addr_lo,
   output logic [LANES-1:0] lane_en_c
);

   always_comb begin
      lane_en_c = '0;
      case (size)
         HSIZE_BYTE: lane_en_c = 4'b0001 << addr_lo;
         HSIZE_HALF: lane_en_c = addr_lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: lane_en_c = 4'b1111;
         default:    lane_en_c = '0;
      endcase
   end

endmodule

// File: rtl/itcm_ahb_slave.sv
// AHB-Lite responder for the ITCM word array with programmable wait states.
// Optional write protection input is enabled by defining ITCM_WRITE_PROTECT_EN.
module itcm_ahb_slave
   import itcm_ahb_slave_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DEPTH_WORDS = 4096,
   parameter int unsigned           WAIT_CYCLES = 0,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic [DATA_W-1:0]     hwdata,
   input  logic                  hready,
`ifdef ITCM_WRITE_PROTECT_EN
   input  logic                  wp,
`endif
   output logic                  hreadyout,
   output logic [1:0]            hresp,
   output logic [DATA_W-1:0]     hrdata
);

   localparam int unsigned           IDX_W      = $clog2(DEPTH_WORDS);
   localparam int unsigned           REGION_LSB = IDX_W + 2;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD  = WAIT_CNT_W'(WAIT_CYCLES);
   localparam bit                    HAS_WAIT   = (WAIT_CYCLES != 0);

   state_t                  state;
   state_t                  state_next;
   logic [WAIT_CNT_W-1:0]   wait_cnt;
   logic [IDX_W-1:0]        idx_q;
   aphase_t                 aph_q;
   logic [DATA_W-1:0]       rdata_q;
   logic [DATA_W-1:0]       mem [DEPTH_WORDS];

   logic                    accept_c;
   logic                    in_range_c;
   logic                    wp_hit_c;
   logic                    legal_c;
   logic [LANES-1:0]        lane_en_c;
   logic                    unused_ahb_c;

   assign unused_ahb_c = ^{hburst, hprot};

`ifdef ITCM_WRITE_PROTECT_EN
   assign wp_hit_c = hwrite & wp;
`else
   assign wp_hit_c = 1'b0;
`endif

   // Base is aligned to the region size, so only the bits above the region are compared.
   assign in_range_c = ((haddr >> REGION_LSB) == (BASE_ADDR >> REGION_LSB));
   assign accept_c   = hsel & hready & hreadyout & is_active(htrans);
   assign legal_c    = in_range_c & (hsize <= HSIZE_WORD)
                     & is_aligned(hsize, haddr[1:0]) & ~wp_hit_c;

   itcm_byte_mask u_byte_mask (
      .size      (aph_q.size),
      .addr_lo   (aph_q.lane),
      .lane_en_c (lane_en_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_WAIT: if (wait_cnt <= WAIT_CNT_W'(1)) state_next = ST_DATA;
         ST_ERR1: state_next = ST_ERR2;
         default: begin
            if (!accept_c)     state_next = ST_IDLE;
            else if (!legal_c) state_next = ST_ERR1;
            else if (HAS_WAIT) state_next = ST_WAIT;
            else               state_next = ST_DATA;
         end
      endcase
   end

   // Read data is presented straight from the array so a read right after a write sees it.
   always_comb begin
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      hrdata    = rdata_q;
      case (state)
         ST_WAIT: hreadyout = 1'b0;
         ST_DATA: if (!aph_q.write) hrdata = mem[idx_q];
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
         end
         ST_ERR2: hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         aph_q    <= '0;
         wait_cnt <= '0;
         rdata_q  <= '0;
      end else begin
         if (accept_c) begin
            idx_q <= haddr[REGION_LSB-1:2];
            aph_q <= '{write: hwrite, size: hsize, lane: haddr[1:0]};
         end
         if (state_next == ST_WAIT && state != ST_WAIT)
            wait_cnt <= WAIT_LOAD;
         else if (state == ST_WAIT)
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
         if (state == ST_DATA && !aph_q.write)
            rdata_q <= mem[idx_q];
      end
   end

   // Writes commit on the edge that closes the data phase; reset on that edge drops them.
   always_ff @(posedge clk) begin
      if (!rst && state == ST_DATA && aph_q.write) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (lane_en_c[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
         end
      end
   end

endmodule
